addsub_share_arbiter: RTL
=========================

Name: addsub_share_arbiter

Overview:
- Shares one 32-bit ripple adder/subtractor between two requesters.
- Each requester presents operands and an add/sub select over a valid/ready handshake.
- Round-robin arbitration picks one request, the shared adder computes the result, and the result is held in a one-entry output register until the consumer accepts it.
- Sits between the integer issue logic and the shared add/sub datapath; it is the only block that drives that datapath.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 16, width of the saturating completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low; sampled on rising clk.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_sub  input  1  requester 0 select: 1 = A-B, 0 = A+B.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub  same directions, widths and meanings for requester 1.
- resp_valid  output  1  result register holds an unconsumed result.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  1  requester that owns the result.
- resp_sum  output  WIDTH  result.
- resp_cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
- resp_ovf  output  1  signed overflow.
- op_count  output  CNT_W  completed-operation count, saturating.

Behaviour:
- Arithmetic, combinational on the granted operands: Bx = B XOR {WIDTH{sub}}; {cout,sum} = A + Bx + sub, computed WIDTH+1 bits wide. ovf = (A[MSB]==Bx[MSB]) && (sum[MSB]!=A[MSB]).
- FSM has two states:
  - IDLE: resp_valid=0.
  - HOLD: resp_valid=1.
- can_accept = (state==IDLE) || (resp_ready).
- Grant, combinational:
  - If only one reqN_valid is set, grant that requester.
  - If both are set, grant the requester != last_grant.
  - If neither is set, grant nothing.
- reqN_ready = can_accept && grant==N. Never asserted for a non-granted requester. Never asserted when reqN_valid=0.
- Accept happens when reqN_valid && reqN_ready at the clock edge. On accept:
  - resp_sum, resp_cout, resp_ovf and resp_id are loaded with the granted result.
  - last_grant is set to N.
  - Next state is HOLD.
- Latency: a request accepted at edge k shows resp_valid=1 with its result after edge k; the result is visible in cycle k+1.
- HOLD, resp_ready=1, new request granted: back-to-back. Stay in HOLD, load the new result, and assert no bubble.
- HOLD, resp_ready=1, no request: go to IDLE and drop resp_valid next cycle.
- HOLD, resp_ready=0: all response outputs hold stable and both req*_ready are 0.
- op_count increments by 1 on each edge where resp_valid && resp_ready. It saturates at 2^CNT_W-1 and does not wrap.
- Reset (rst_n=0 at an edge), including mid-HOLD:
  - state=IDLE, resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0, resp_ovf=0.
  - op_count=0, last_grant=1, so requester 0 wins the first tie.
  - Any pending result is discarded and not counted.
  - req*_ready=0 while rst_n=0.
- Protocol rules on requesters: a requester may not drop valid or change operands while its valid=1 and ready=0. The block does not check this.
- Simultaneous events: response drain and a new accept in the same edge are both honoured. op_count increments and the new result loads.

Test Plan:
- Reset, then req0: a=0x0000_0005, b=0x0000_0003, sub=0, resp_ready=1 -> req0_ready=1 the same cycle. Next cycle shows resp_valid=1, resp_id=0, resp_sum=0x0000_0008, cout=0, ovf=0, and op_count becomes 1 on drain.
- req1: a=0x0000_0003, b=0x0000_0005, sub=1 -> sum=0xFFFF_FFFE, cout=0 (borrow), ovf=0. Then a=0x8000_0000, b=0x0000_0001, sub=1 -> sum=0x7FFF_FFFF, cout=1, ovf=1.
- Both valid continuously with resp_ready=1 for 6 cycles -> grants alternate 0,1,0,1,0,1 starting with 0 after reset. resp_valid stays 1 with no bubbles, and op_count=6 after the drains.
- resp_ready=0 for 4 cycles while HOLD with both requesters valid -> both req*_ready=0 and resp_* stable. On resp_ready=1, the next grant follows round-robin order.
- Assert rst_n=0 for 1 cycle while in HOLD holding 0x7FFF_FFFF+1 (ovf=1) -> next cycle resp_valid=0, all resp_* are 0 and op_count=0. The first tie after reset is granted to requester 0.
- With CNT_W=4, complete 20 operations -> op_count reads 15 and stays at 15.

Source files
------------

// File: rtl/addsub_share_arbiter_if.sv
// Requester/consumer bundle for the shared add/sub arbiter.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1. Once valid is raised it stays high, with stable payload, until that
// transfer happens. ready may depend combinationally on valid and on the
// consumer's resp_ready.
interface addsub_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_sub;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_sub;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_sum;
  logic             resp_cout;
  logic             resp_ovf;
  logic [CNT_W-1:0] op_count;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_sum, resp_cout, resp_ovf, op_count
  );

  // Requester/consumer side
  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_sum, resp_cout, resp_ovf, op_count
  );
endinterface

// File: rtl/addsub_share_arbiter.sv
// Two requesters share one ripple adder/subtractor. Round-robin grant, one
// result register drained by a valid/ready consumer, saturating op counter.
module addsub_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  addsub_share_arbiter_if.slave  bus,
  output logic                   o_dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_last_grant;
  logic             r_id;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;

  logic             w_resp_valid;
  logic             w_can_accept;
  logic             w_gnt_valid;
  logic             w_gnt_id;
  logic             w_accept;
  logic             w_drain;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_sub;
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH:0]   w_full;
  logic             w_ovf;

  // Grant: a lone requester wins; on a tie the one not served last wins.
  assign w_gnt_valid  = bus.req0_valid | bus.req1_valid;
  assign w_gnt_id     = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant
                                                           : bus.req1_valid;
  assign w_can_accept = (r_state == S_IDLE) || bus.resp_ready;
  assign w_accept     = rst_n && w_can_accept && w_gnt_valid;
  assign w_drain      = w_resp_valid && bus.resp_ready;

  assign bus.req0_ready = w_accept && (w_gnt_id == 1'b0);
  assign bus.req1_ready = w_accept && (w_gnt_id == 1'b1);

  // Shared datapath on the granted operands; subtract is A + ~B + 1.
  assign w_a    = w_gnt_id ? bus.req1_a   : bus.req0_a;
  assign w_b    = w_gnt_id ? bus.req1_b   : bus.req0_b;
  assign w_sub  = w_gnt_id ? bus.req1_sub : bus.req0_sub;
  assign w_bx   = w_b ^ {WIDTH{w_sub}};
  assign w_full = {1'b0, w_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_sub};
  assign w_ovf  = (w_a[WIDTH-1] == w_bx[WIDTH-1]) &&
                  (w_full[WIDTH-1] != w_a[WIDTH-1]);

  // Next state: HOLD while a result is owned or a new one loads, else IDLE.
  always_comb begin
    w_next_state = r_state;
    w_resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_HOLD;
      end
      S_HOLD: begin
        w_resp_valid = 1'b1;
        if (!w_accept && bus.resp_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register; reset discards any held result.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Result register and round-robin pointer load on every accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_sum        <= '0;
      r_cout       <= 1'b0;
      r_ovf        <= 1'b0;
    end else if (w_accept) begin
      r_last_grant <= w_gnt_id;
      r_id         <= w_gnt_id;
      r_sum        <= w_full[WIDTH-1:0];
      r_cout       <= w_full[WIDTH];
      r_ovf        <= w_ovf;
    end
  end

  // Completed-operation counter, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_drain && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_id    = r_id;
  assign bus.resp_sum   = r_sum;
  assign bus.resp_cout  = r_cout;
  assign bus.resp_ovf   = r_ovf;
  assign bus.op_count   = r_cnt;
  assign o_dbg_state    = r_state;

endmodule
